// File: rtl/draw_brick_raster_if.sv
// -----------------------------------------------------------------------------
// draw_brick_raster_if
//   Groups the request and pixel-stream handshakes used by draw_brick_raster.
//   Signal names keep the _i/_o suffixes as seen from the drawing engine.
//
//   Request channel : req_valid_i, req_ready_o, req_col_i, req_row_i, req_color_i
//   Pixel channel   : pix_valid_o, pix_ready_i, pix_x_o, pix_y_o, pix_color_o,
//                     pix_last_o
//
//   modport slave  : the drawing engine (accepts requests, emits pixels)
//   modport master : the client (issues requests, consumes pixels)
// -----------------------------------------------------------------------------
interface draw_brick_raster_if #(
    parameter int PIX_WIDTH   = 12,
    parameter int COLOR_WIDTH = 12,
    parameter int COL_WIDTH   = 4,
    parameter int ROW_WIDTH   = 5
);
    logic                   req_valid_i;
    logic                   req_ready_o;
    logic [COL_WIDTH-1:0]   req_col_i;
    logic [ROW_WIDTH-1:0]   req_row_i;
    logic [COLOR_WIDTH-1:0] req_color_i;

    logic                   pix_valid_o;
    logic                   pix_ready_i;
    logic [PIX_WIDTH-1:0]   pix_x_o;
    logic [PIX_WIDTH-1:0]   pix_y_o;
    logic [COLOR_WIDTH-1:0] pix_color_o;
    logic                   pix_last_o;

    modport slave (
        input  req_valid_i, req_col_i, req_row_i, req_color_i, pix_ready_i,
        output req_ready_o, pix_valid_o, pix_x_o, pix_y_o, pix_color_o, pix_last_o
    );

    modport master (
        output req_valid_i, req_col_i, req_row_i, req_color_i, pix_ready_i,
        input  req_ready_o, pix_valid_o, pix_x_o, pix_y_o, pix_color_o, pix_last_o
    );
endinterface

// File: rtl/draw_brick_raster.sv
// -----------------------------------------------------------------------------
// draw_brick_raster
//   Rasterises one brick of a brick field per request. A request names a
//   brick by column/row; the engine emits BRICK_X*BRICK_Y pixel beats in
//   raster order (x fastest), each carrying absolute coordinates and colour.
//
//   Ports:
//     clk_i      : clock
//     rst_i      : asynchronous reset, active low
//     start_x_i  : field origin x (sampled when a request is accepted)
//     start_y_i  : field origin y (sampled when a request is accepted)
//     bus        : draw_brick_raster_if.slave (request + pixel handshakes)
//     busy_o     : high while a brick is being prepared or streamed
//     err_o      : one-cycle pulse after an out-of-range request
//
//   Optional feature: define DRAW_BRICK_FRAME_EN to paint the outer ring of
//   each brick with FRAME_COLOR; otherwise every beat uses the request colour.
// -----------------------------------------------------------------------------
module draw_brick_raster #(
    parameter int PIX_WIDTH   = 12,
    parameter int BRICK_X     = 20,
    parameter int BRICK_Y     = 25,
    parameter int BRICK_X_CNT = 10,
    parameter int BRICK_Y_CNT = 20,
    parameter int BORDER_X    = 2,
    parameter int BORDER_Y    = 2,
    parameter int COLOR_WIDTH = 12,
    parameter logic [COLOR_WIDTH-1:0] FRAME_COLOR = 12'hFFF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [PIX_WIDTH-1:0] start_x_i,
    input  logic [PIX_WIDTH-1:0] start_y_i,
    draw_brick_raster_if.slave   bus,
    output logic                 busy_o,
    output logic                 err_o
);

    localparam int COL_WIDTH = (BRICK_X_CNT > 1) ? $clog2(BRICK_X_CNT) : 1;
    localparam int ROW_WIDTH = (BRICK_Y_CNT > 1) ? $clog2(BRICK_Y_CNT) : 1;
    localparam int CX_WIDTH  = (BRICK_X > 1) ? $clog2(BRICK_X) : 1;
    localparam int CY_WIDTH  = (BRICK_Y > 1) ? $clog2(BRICK_Y) : 1;

    localparam logic [CX_WIDTH-1:0] CX_LAST = CX_WIDTH'(BRICK_X - 1);
    localparam logic [CY_WIDTH-1:0] CY_LAST = CY_WIDTH'(BRICK_Y - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [COL_WIDTH-1:0]   col_q, col_d;
    logic [ROW_WIDTH-1:0]   row_q, row_d;
    logic [COLOR_WIDTH-1:0] color_q, color_d;
    logic [PIX_WIDTH-1:0]   start_x_q, start_x_d;
    logic [PIX_WIDTH-1:0]   start_y_q, start_y_d;
    logic [PIX_WIDTH-1:0]   base_x_q, base_x_d;
    logic [PIX_WIDTH-1:0]   base_y_q, base_y_d;
    logic [CX_WIDTH-1:0]    cx_q, cx_d;
    logic [CY_WIDTH-1:0]    cy_q, cy_d;
    logic                   err_q, err_d;

    logic                   req_ready;
    logic                   accept;
    logic                   in_range;
    logic                   running;
    logic                   last_beat;
    logic [PIX_WIDTH-1:0]   col_ext;
    logic [PIX_WIDTH-1:0]   row_ext;
    logic [PIX_WIDTH-1:0]   off_x;
    logic [PIX_WIDTH-1:0]   off_y;
    logic [COLOR_WIDTH-1:0] beat_color;

    // Next-state and datapath
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        color_d   = color_q;
        start_x_d = start_x_q;
        start_y_d = start_y_q;
        base_x_d  = base_x_q;
        base_y_d  = base_y_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        err_d     = 1'b0;

        // Ready is masked by reset so it reads 0 while rst_i is held low and
        // rises in the first cycle after release.
        req_ready = (state_q == IDLE) && rst_i;
        accept    = bus.req_valid_i && req_ready;
        in_range  = (32'(bus.req_col_i) < 32'(BRICK_X_CNT)) &&
                    (32'(bus.req_row_i) < 32'(BRICK_Y_CNT));
        last_beat = (cx_q == CX_LAST) && (cy_q == CY_LAST);

        // Brick origin offset: one leading gap plus col gaps/bricks before it.
        col_ext = PIX_WIDTH'(col_q);
        row_ext = PIX_WIDTH'(row_q);
        off_x   = (col_ext + PIX_WIDTH'(1)) * PIX_WIDTH'(BORDER_X)
                + col_ext * PIX_WIDTH'(BRICK_X);
        off_y   = (row_ext + PIX_WIDTH'(1)) * PIX_WIDTH'(BORDER_Y)
                + row_ext * PIX_WIDTH'(BRICK_Y);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_range) begin
                        col_d     = bus.req_col_i;
                        row_d     = bus.req_row_i;
                        color_d   = bus.req_color_i;
                        start_x_d = start_x_i;
                        start_y_d = start_y_i;
                        state_d   = CALC;
                    end else begin
                        // Out-of-range brick is consumed and flagged only.
                        err_d = 1'b1;
                    end
                end
            end
            CALC: begin
                base_x_d = start_x_q + off_x;
                base_y_d = start_y_q + off_y;
                cx_d     = '0;
                cy_d     = '0;
                state_d  = RUN;
            end
            RUN: begin
                if (bus.pix_ready_i) begin
                    if (cx_q == CX_LAST) begin
                        cx_d = '0;
                        if (last_beat) begin
                            cy_d    = '0;
                            state_d = IDLE;
                        end else begin
                            cy_d = cy_q + CY_WIDTH'(1);
                        end
                    end else begin
                        cx_d = cx_q + CX_WIDTH'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef DRAW_BRICK_FRAME_EN
    always_comb begin
        if ((cx_q == '0) || (cx_q == CX_LAST) || (cy_q == '0) || (cy_q == CY_LAST))
            beat_color = FRAME_COLOR;
        else
            beat_color = color_q;
    end
`else
    always_comb begin
        beat_color = color_q;
    end

    // FRAME_COLOR is only consumed by the framed build.
    logic unused_frame_color;
    assign unused_frame_color = ^FRAME_COLOR;
`endif

    // Outputs are forced to zero outside RUN so reset clears them immediately.
    always_comb begin
        running         = (state_q == RUN);
        bus.req_ready_o = req_ready;
        bus.pix_valid_o = running;
        bus.pix_x_o     = running ? (base_x_q + PIX_WIDTH'(cx_q)) : '0;
        bus.pix_y_o     = running ? (base_y_q + PIX_WIDTH'(cy_q)) : '0;
        bus.pix_color_o = running ? beat_color : '0;
        bus.pix_last_o  = running && last_beat;
        busy_o          = (state_q != IDLE);
        err_o           = err_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            color_q   <= '0;
            start_x_q <= '0;
            start_y_q <= '0;
            base_x_q  <= '0;
            base_y_q  <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            color_q   <= color_d;
            start_x_q <= start_x_d;
            start_y_q <= start_y_d;
            base_x_q  <= base_x_d;
            base_y_q  <= base_y_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_draw_brick_raster.sv
module tb_draw_brick_raster;

    localparam int PW     = 12;
    localparam int CW     = 12;
    localparam int BX     = 20;
    localparam int BY     = 25;
    localparam int BX_CNT = 10;
    localparam int BY_CNT = 20;
    localparam int GAP_X  = 2;
    localparam int GAP_Y  = 2;
    localparam int COL_W  = 4;
    localparam int ROW_W  = 5;
    localparam logic [CW-1:0] FRAME_C = 12'hFFF;

    typedef struct {
        logic [PW-1:0] x;
        logic [PW-1:0] y;
        logic [CW-1:0] c;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [PW-1:0] start_x;
    logic [PW-1:0] start_y;
    logic          busy;
    logic          err;

    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    int    ready_pct = 100;
    int    brick_beat = 0;
    int    first_cyc = 0;
    int    last_cyc = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    draw_brick_raster_if #(
        .PIX_WIDTH(PW), .COLOR_WIDTH(CW), .COL_WIDTH(COL_W), .ROW_WIDTH(ROW_W)
    ) bus ();

    draw_brick_raster #(
        .PIX_WIDTH(PW), .BRICK_X(BX), .BRICK_Y(BY),
        .BRICK_X_CNT(BX_CNT), .BRICK_Y_CNT(BY_CNT),
        .BORDER_X(GAP_X), .BORDER_Y(GAP_Y),
        .COLOR_WIDTH(CW), .FRAME_COLOR(FRAME_C)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_n),
        .start_x_i(start_x),
        .start_y_i(start_y),
        .bus      (bus),
        .busy_o   (busy),
        .err_o    (err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] pack(input beat_t b);
        return 64'({b.x, b.y, b.c, b.last});
    endfunction

    // Reference model: brick origin from gap/brick arithmetic, raster order.
    task automatic push_brick(input int sx, input int sy, input int col, input int row,
                              input logic [CW-1:0] color);
        int    ox;
        int    oy;
        beat_t b;
        ox = sx + (col + 1) * GAP_X + col * BX;
        oy = sy + (row + 1) * GAP_Y + row * BY;
        for (int y = 0; y < BY; y++) begin
            for (int x = 0; x < BX; x++) begin
                b.x    = PW'((ox + x) % (1 << PW));
                b.y    = PW'((oy + y) % (1 << PW));
`ifdef DRAW_BRICK_FRAME_EN
                b.c    = (x == 0 || x == BX - 1 || y == 0 || y == BY - 1) ? FRAME_C : color;
`else
                b.c    = color;
`endif
                b.last = (x == BX - 1) && (y == BY - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    // Monitor: pops the scoreboard on every transfer, checks stall stability.
    initial begin
        beat_t cur;
        beat_t held;
        beat_t e;
        bit    stalled;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
                continue;
            end
            cur.x    = bus.pix_x_o;
            cur.y    = bus.pix_y_o;
            cur.c    = bus.pix_color_o;
            cur.last = bus.pix_last_o;
            if (bus.pix_valid_o) begin
                if (stalled)
                    check("stall_hold", pack(cur), pack(held));
                if (bus.pix_ready_i) begin
                    stalled = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 64'(1), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", pack(cur), pack(e));
                        if (brick_beat == 0) first_cyc = cyc;
                        if (e.last) begin
                            last_cyc   = cyc;
                            brick_beat = 0;
                        end else begin
                            brick_beat++;
                        end
                    end
                end else begin
                    stalled = 1'b1;
                    held    = cur;
                end
            end else begin
                stalled = 1'b0;
                if (bus.pix_last_o) check("last_without_valid", 64'(1), 64'(0));
            end
        end
    end

    // Pixel-side backpressure
    initial begin
        bus.pix_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.pix_ready_i = ($urandom_range(99, 0) < ready_pct);
        end
    end

    task automatic issue(input int col, input int row, input logic [CW-1:0] color,
                         input logic [PW-1:0] sx, input logic [PW-1:0] sy,
                         input bit wait_done);
        bit valid_req;
        int n;
        valid_req = (col < BX_CNT) && (row < BY_CNT);
        @(posedge clk);
        #1;
        start_x         = sx;
        start_y         = sy;
        bus.req_col_i   = COL_W'(col);
        bus.req_row_i   = ROW_W'(row);
        bus.req_color_i = color;
        bus.req_valid_i = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.req_ready_o) break;
            n++;
            if (n > 3000) begin
                check("req_ready_timeout", 64'(0), 64'(1));
                bus.req_valid_i = 1'b0;
                return;
            end
        end
        if (valid_req) push_brick(int'(sx), int'(sy), col, row, color);
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        // Origin inputs must not influence the brick already accepted.
        start_x = PW'($urandom);
        start_y = PW'($urandom);
        if (!valid_req) begin
            @(negedge clk);
            check("err_pulse", 64'(err), 64'(1));
            check("err_no_busy", 64'({busy, bus.pix_valid_o, bus.req_ready_o}), 64'(3'b001));
            @(negedge clk);
            check("err_clears", 64'({err, bus.pix_valid_o, bus.req_ready_o}), 64'(3'b001));
            return;
        end
        @(negedge clk);
        check("calc_cycle", 64'({busy, bus.pix_valid_o, bus.req_ready_o}), 64'(3'b100));
        @(negedge clk);
        check("first_beat_latency", 64'(bus.pix_valid_o), 64'(1));
        if (!wait_done) return;
        n = 0;
        while (exp_q.size() != 0 || busy) begin
            @(negedge clk);
            n++;
            if (n > 5000) begin
                check("brick_timeout", 64'(exp_q.size()), 64'(0));
                return;
            end
        end
        check("back_to_idle", 64'({busy, bus.req_ready_o}), 64'(2'b01));
        if (ready_pct == 100)
            check("throughput", 64'(last_cyc - first_cyc), 64'(BX * BY - 1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        int n;
        int col;
        int row;
        rst_n           = 1'b0;
        start_x         = '0;
        start_y         = '0;
        bus.req_valid_i = 1'b0;
        bus.req_col_i   = '0;
        bus.req_row_i   = '0;
        bus.req_color_i = '0;

        #12;
        check("reset_ctrl", 64'({bus.req_ready_o, busy, err, bus.pix_valid_o, bus.pix_last_o}), 64'(0));
        check("reset_pix", 64'({bus.pix_x_o, bus.pix_y_o, bus.pix_color_o}), 64'(0));
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1 check("ready_after_reset", 64'(bus.req_ready_o), 64'(1));

        // Directed origin/colour cases
        ready_pct = 100;
        issue(0, 0, 12'h0F0, 12'd100, 12'd50, 1'b1);
        issue(9, 19, 12'h0F0, 12'd100, 12'd50, 1'b1);
        ready_pct = 50;
        issue(0, 0, 12'h0F0, 12'd100, 12'd50, 1'b1);

        // Out-of-range requests
        ready_pct = 100;
        issue(10, 0, 12'h123, 12'd100, 12'd50, 1'b1);
        issue(0, 20, 12'h123, 12'd100, 12'd50, 1'b1);

        // Reset mid-burst
        issue(0, 0, 12'h0F0, 12'd100, 12'd50, 1'b0);
        n = 0;
        while (brick_beat < 37 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_beat_37", 64'(brick_beat >= 37), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("async_abort", 64'({bus.pix_valid_o, bus.pix_last_o, busy, bus.req_ready_o}), 64'(0));
        exp_q.delete();
        brick_beat = 0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1 check("ready_after_abort", 64'(bus.req_ready_o), 64'(1));
        issue(3, 7, 12'hA5C, 12'd100, 12'd50, 1'b1);

        // Randomised bricks, including wrapped origins and stray requests
        for (int i = 0; i < 8; i++) begin
            ready_pct = ($urandom_range(2, 0) == 0) ? 100 : int'($urandom_range(90, 30));
            if ($urandom_range(4, 0) == 0) begin
                col = int'($urandom_range(15, 10));
                row = int'($urandom_range(19, 0));
            end else begin
                col = int'($urandom_range(BX_CNT - 1, 0));
                row = int'($urandom_range(BY_CNT - 1, 0));
            end
            issue(col, row, CW'($urandom), PW'($urandom), PW'($urandom), 1'b1);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
